mem_port_arbiter: RTL

//  Shares the core's single-port unified memory between instruction fetch (IF) and load/store (D).

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/arb_timeout_cnt.sv | 21 ++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Sliced down to DW/8 bits by users; fetches always read whole words.
    localparam logic [63:0] BE_ALL = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_gnt;
    logic            if_valid;
    logic [DW-1:0]   if_rdata;
    logic            if_err;

    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_be;
    logic            d_gnt;
    logic            d_valid;
    logic [DW-1:0]   d_rdata;
    logic            d_err;

    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic [DW-1:0]   mem_rdata;
    logic            mem_ack;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_valid, if_rdata, if_err,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_valid, d_rdata, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    // Fetch stage, LSU and memory model side.
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_valid, if_rdata, if_err,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_valid, d_rdata, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/arb_timeout_cnt.sv
// Clear/enable counter that stops at a limit and flags when it is there.
module arb_timeout_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         hit
);
    logic [W-1:0] cnt;

    assign hit = (cnt == limit);

    always_ff @(posedge clk) begin
        if (!rst)            cnt <= '0;
        else if (clr)        cnt <= '0;
        else if (en && !hit) cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store:
// one transaction at a time, data priority with a fetch starvation guard.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int BW = DW / 8;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    arb_state_t    state, state_nxt;
    owner_t        owner;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [BW-1:0] lat_be;
    logic [DW-1:0] rdata_q;
    logic          err_q;
    logic [SW-1:0] starve_cnt;

    logic busy, if_win, gnt_if, gnt_d, tmo_hit, if_done, d_done;

    assign busy   = (state == BUSY_IF) || (state == BUSY_D);
    assign if_win = bus.if_req && (!bus.d_req || starve_cnt == SW'(STARVE_MAX));
    // Grants are masked during reset so a request can't be accepted and then dropped.
    assign gnt_if = rst && (state == IDLE) && if_win;
    assign gnt_d  = rst && (state == IDLE) && bus.d_req && !if_win;

    // Counts unacked BUSY cycles; cleared whenever not BUSY, i.e. on every BUSY entry.
    arb_timeout_cnt #(.W(TW)) u_tmo (
        .clk   (clk),
        .rst   (rst),
        .clr   (!busy),
        .en    (busy && !bus.mem_ack),
        .limit (TW'(TIMEOUT - 1)),
        .hit   (tmo_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:           if (gnt_d) state_nxt = BUSY_D;
                            else if (gnt_if) state_nxt = BUSY_IF;
            BUSY_IF,
            BUSY_D:         if (bus.mem_ack || tmo_hit) state_nxt = DONE;
            DONE:           state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner      <= OWN_IF;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_be     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (gnt_d) begin
                owner     <= OWN_D;
                lat_we    <= bus.d_we;
                lat_addr  <= bus.d_addr;
                lat_wdata <= bus.d_wdata;
                lat_be    <= bus.d_be;
            end else if (gnt_if) begin
                owner     <= OWN_IF;
                lat_we    <= 1'b0;
                lat_addr  <= bus.if_addr;
                lat_wdata <= '0;
                lat_be    <= BE_ALL[BW-1:0];
            end
            // Fetch always wins at the limit, so the counter can't pass STARVE_MAX.
            if (gnt_if)                   starve_cnt <= '0;
            else if (gnt_d && bus.if_req) starve_cnt <= starve_cnt + SW'(1);
            // An ack on the limit cycle takes precedence over the timeout.
            if (busy) begin
                if (bus.mem_ack) begin
                    rdata_q <= lat_we ? '0 : bus.mem_rdata;
                    err_q   <= 1'b0;
                end else if (tmo_hit) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign if_done = (state == DONE) && (owner == OWN_IF);
    assign d_done  = (state == DONE) && (owner == OWN_D);

    assign bus.if_gnt    = gnt_if;
    assign bus.if_valid  = if_done;
    assign bus.if_rdata  = if_done ? rdata_q : '0;
    assign bus.if_err    = if_done && err_q;

    assign bus.d_gnt     = gnt_d;
    assign bus.d_valid   = d_done;
    assign bus.d_rdata   = d_done ? rdata_q : '0;
    assign bus.d_err     = d_done && err_q;

    assign bus.mem_req   = busy;
    assign bus.mem_we    = busy && lat_we;
    assign bus.mem_addr  = busy ? lat_addr : '0;
    assign bus.mem_wdata = busy ? lat_wdata : '0;
    assign bus.mem_be    = busy ? lat_be : '0;
endmodule
